// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared combinational RV32I ALU, with one-entry
// tagged response slots per port. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins).
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input  logic                   Clk,
  input  logic                   RstN,
  input  logic                   Req0Valid,
  output logic                   Req0Ready,
  input  logic [DATA_WIDTH-1:0]  Req0Op1,
  input  logic [DATA_WIDTH-1:0]  Req0Op2,
  input  logic [INSTR_WIDTH-1:0] Req0Instr,
  input  logic [TAG_WIDTH-1:0]   Req0Tag,
  input  logic                   Req1Valid,
  output logic                   Req1Ready,
  input  logic [DATA_WIDTH-1:0]  Req1Op1,
  input  logic [DATA_WIDTH-1:0]  Req1Op2,
  input  logic [INSTR_WIDTH-1:0] Req1Instr,
  input  logic [TAG_WIDTH-1:0]   Req1Tag,
  output logic                   Rsp0Valid,
  input  logic                   Rsp0Ready,
  output logic [DATA_WIDTH-1:0]  Rsp0Data,
  output logic [TAG_WIDTH-1:0]   Rsp0Tag,
  output logic                   Rsp1Valid,
  input  logic                   Rsp1Ready,
  output logic [DATA_WIDTH-1:0]  Rsp1Data,
  output logic [TAG_WIDTH-1:0]   Rsp1Tag,
  output logic [DATA_WIDTH-1:0]  AluOp1,
  output logic [DATA_WIDTH-1:0]  AluOp2,
  output logic [INSTR_WIDTH-1:0] AluInstr,
  input  logic [DATA_WIDTH-1:0]  AluOut
);

  logic                  r_rsp0_valid;
  logic [DATA_WIDTH-1:0] r_rsp0_data;
  logic [TAG_WIDTH-1:0]  r_rsp0_tag;
  logic                  r_rsp1_valid;
  logic [DATA_WIDTH-1:0] r_rsp1_data;
  logic [TAG_WIDTH-1:0]  r_rsp1_tag;

  logic w_elig0;
  logic w_elig1;
  logic w_gnt0;
  logic w_gnt1;

  // A port may issue only if its slot is empty or being drained this cycle.
  assign w_elig0 = Req0Valid && (!r_rsp0_valid || Rsp0Ready);
  assign w_elig1 = Req1Valid && (!r_rsp1_valid || Rsp1Ready);

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic r_last_grant;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_gnt0 = w_elig0;
    w_gnt1 = w_elig1;
    if (w_elig0 && w_elig1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_gnt0 = 1'b1;
      w_gnt1 = 1'b0;
`else
      w_gnt0 = r_last_grant;
      w_gnt1 = !r_last_grant;
`endif
    end
  end

  assign Req0Ready = w_gnt0;
  assign Req1Ready = w_gnt1;

  // Idle ALU sees all-zero inputs; instruction 0 decodes as a harmless ADD.
  always_comb begin
    AluOp1   = '0;
    AluOp2   = '0;
    AluInstr = '0;
    if (w_gnt0) begin
      AluOp1   = Req0Op1;
      AluOp2   = Req0Op2;
      AluInstr = Req0Instr;
    end else if (w_gnt1) begin
      AluOp1   = Req1Op1;
      AluOp2   = Req1Op2;
      AluInstr = Req1Instr;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Reset value 1 hands the first conflict to port 0.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      r_last_grant <= 1'b1;
    end else if (w_gnt0) begin
      r_last_grant <= 1'b0;
    end else if (w_gnt1) begin
      r_last_grant <= 1'b1;
    end
  end
`endif

  // A grant reloads the slot even while it drains, giving one result per cycle per port.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp0_tag   <= '0;
    end else if (w_gnt0) begin
      r_rsp0_valid <= 1'b1;
      r_rsp0_data  <= AluOut;
      r_rsp0_tag   <= Req0Tag;
    end else if (Rsp0Ready) begin
      r_rsp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= '0;
      r_rsp1_tag   <= '0;
    end else if (w_gnt1) begin
      r_rsp1_valid <= 1'b1;
      r_rsp1_data  <= AluOut;
      r_rsp1_tag   <= Req1Tag;
    end else if (Rsp1Ready) begin
      r_rsp1_valid <= 1'b0;
    end
  end

  assign Rsp0Valid = r_rsp0_valid;
  assign Rsp0Data  = r_rsp0_data;
  assign Rsp0Tag   = r_rsp0_tag;
  assign Rsp1Valid = r_rsp1_valid;
  assign Rsp1Data  = r_rsp1_data;
  assign Rsp1Tag   = r_rsp1_tag;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a small RV32I ALU model stands in for the real ALU and a
// per-port scoreboard queue checks every returned result and tag.
module tb_alu_arbiter;

  localparam logic [31:0] I_ADD = 32'h0000_0033;
  localparam logic [31:0] I_SUB = 32'h4000_0033;
  localparam logic [31:0] I_OR  = 32'h0000_6033;
  localparam logic [31:0] I_XOR = 32'h0000_4033;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  logic        Clk = 1'b0;
  logic        RstN;
  logic        Req0Valid, Req1Valid;
  logic        Req0Ready, Req1Ready;
  logic [31:0] Req0Op1, Req0Op2, Req0Instr, Req1Op1, Req1Op2, Req1Instr;
  logic [3:0]  Req0Tag, Req1Tag;
  logic        Rsp0Valid, Rsp1Valid, Rsp0Ready, Rsp1Ready;
  logic [31:0] Rsp0Data, Rsp1Data;
  logic [3:0]  Rsp0Tag, Rsp1Tag;
  logic [31:0] AluOp1, AluOp2, AluInstr, AluOut;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic        last_g0, last_g1;
  logic [31:0] last_op1, last_op2, last_instr;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] instr);
    logic alt;
    alt = instr[30] && (instr[6:0] == 7'h33);
    case (instr[14:12])
      3'd0:    alu_model = alt ? (a - b) : (a + b);
      3'd1:    alu_model = a << b[4:0];
      3'd4:    alu_model = a ^ b;
      3'd5:    alu_model = a >> b[4:0];
      3'd6:    alu_model = a | b;
      3'd7:    alu_model = a & b;
      default: alu_model = a + b;
    endcase
  endfunction

  assign AluOut = alu_model(AluOp1, AluOp2, AluInstr);

  always #5 Clk = ~Clk;

  alu_arbiter dut (
    .Clk(Clk), .RstN(RstN),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Op1(Req0Op1), .Req0Op2(Req0Op2),
    .Req0Instr(Req0Instr), .Req0Tag(Req0Tag),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Op1(Req1Op1), .Req1Op2(Req1Op2),
    .Req1Instr(Req1Instr), .Req1Tag(Req1Tag),
    .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready), .Rsp0Data(Rsp0Data), .Rsp0Tag(Rsp0Tag),
    .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready), .Rsp1Data(Rsp1Data), .Rsp1Tag(Rsp1Tag),
    .AluOp1(AluOp1), .AluOp2(AluOp2), .AluInstr(AluInstr), .AluOut(AluOut)
  );

  // One clock: sample at the falling edge, retire/record results, then return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge Clk);
    last_g0 = Req0Ready;
    last_g1 = Req1Ready;
    last_op1 = AluOp1;
    last_op2 = AluOp2;
    last_instr = AluInstr;
    n_tests++;
    if (last_g0 && last_g1) begin
      n_fail++;
      $display("FAIL dual_grant: Req0Ready=%b Req1Ready=%b, required at most one", last_g0, last_g1);
    end
    if (Rsp0Valid && Rsp0Ready) begin
      n_tests++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL sb0_unexpected: got data=%h tag=%h, required no response", Rsp0Data, Rsp0Tag);
      end else begin
        e = q0.pop_front();
        if (Rsp0Data !== e.data || Rsp0Tag !== e.tag) begin
          n_fail++;
          $display("FAIL sb0_result: got data=%h tag=%h, required data=%h tag=%h",
                   Rsp0Data, Rsp0Tag, e.data, e.tag);
        end
      end
    end
    if (Rsp1Valid && Rsp1Ready) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL sb1_unexpected: got data=%h tag=%h, required no response", Rsp1Data, Rsp1Tag);
      end else begin
        e = q1.pop_front();
        if (Rsp1Data !== e.data || Rsp1Tag !== e.tag) begin
          n_fail++;
          $display("FAIL sb1_result: got data=%h tag=%h, required data=%h tag=%h",
                   Rsp1Data, Rsp1Tag, e.data, e.tag);
        end
      end
    end
    if (Req0Valid && Req0Ready) q0.push_back('{alu_model(Req0Op1, Req0Op2, Req0Instr), Req0Tag});
    if (Req1Valid && Req1Ready) q1.push_back('{alu_model(Req1Op1, Req1Op2, Req1Instr), Req1Tag});
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Req0Valid = 1'b0; Req0Op1 = '0; Req0Op2 = '0; Req0Instr = '0; Req0Tag = '0;
    Req1Valid = 1'b0; Req1Op1 = '0; Req1Op2 = '0; Req1Instr = '0; Req1Tag = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    Rsp0Ready = 1'b1;
    Rsp1Ready = 1'b1;
    RstN = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    RstN = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    idle_inputs();
    Rsp0Ready = 1'b1;
    Rsp1Ready = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0 || Rsp0Valid !== 1'b0 || Rsp1Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: pending q0=%0d q1=%0d Rsp0Valid=%b Rsp1Valid=%b, required all empty",
               q0.size(), q1.size(), Rsp0Valid, Rsp1Valid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({Rsp0Valid, Rsp0Data, Rsp0Tag, Rsp1Valid, Rsp1Data, Rsp1Tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: rsp0 v=%b d=%h t=%h rsp1 v=%b d=%h t=%h, required all 0",
               Rsp0Valid, Rsp0Data, Rsp0Tag, Rsp1Valid, Rsp1Data, Rsp1Tag);
    end
    n_tests++;
    if ({Req0Ready, Req1Ready, AluOp1, AluOp2, AluInstr} !== '0) begin
      n_fail++;
      $display("FAIL reset_alu: ready=%b%b op1=%h op2=%h instr=%h, required all 0",
               Req0Ready, Req1Ready, AluOp1, AluOp2, AluInstr);
    end
  endtask

  task automatic test_single();
    Req0Valid = 1'b1; Req0Op1 = 32'd5; Req0Op2 = 32'd7; Req0Instr = I_ADD; Req0Tag = 4'd3;
    tick();
    n_tests++;
    if (last_g0 !== 1'b1 || last_g1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: g0=%b g1=%b, required g0=1 g1=0", last_g0, last_g1);
    end
    Req0Valid = 1'b0;
    n_tests++;
    if (Rsp0Valid !== 1'b1 || Rsp0Data !== 32'd12 || Rsp0Tag !== 4'd3 || Rsp1Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: v0=%b d=%h t=%h v1=%b, required v0=1 d=0000000c t=3 v1=0",
               Rsp0Valid, Rsp0Data, Rsp0Tag, Rsp1Valid);
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic exp_g0;
    apply_reset();
    Req0Valid = 1'b1; Req0Op1 = 32'd100; Req0Op2 = 32'd1; Req0Instr = I_ADD; Req0Tag = 4'd1;
    Req1Valid = 1'b1; Req1Op1 = 32'd200; Req1Op2 = 32'd2; Req1Instr = I_SUB; Req1Tag = 4'd9;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g0 = 1'b1;
`else
      exp_g0 = (i % 2 == 0);
`endif
      n_tests++;
      if (last_g0 !== exp_g0 || last_g1 !== !exp_g0) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: g0=%b g1=%b, required g0=%b g1=%b",
                 i, last_g0, last_g1, exp_g0, !exp_g0);
      end
      // Only a port that just handshook may change its request.
      if (last_g0) begin
        Req0Op1 = $urandom; Req0Op2 = $urandom; Req0Tag = Req0Tag + 4'd1;
      end
      if (last_g1) begin
        Req1Op1 = $urandom; Req1Op2 = $urandom; Req1Instr = I_XOR; Req1Tag = Req1Tag + 4'd1;
      end
    end
    drain();
  endtask

  task automatic test_blocked();
    Rsp0Ready = 1'b0;
    Req0Valid = 1'b1; Req0Op1 = 32'hF0; Req0Op2 = 32'h0F; Req0Instr = I_OR; Req0Tag = 4'd6;
    tick();
    Req0Op1 = 32'd1; Req0Op2 = 32'd2; Req0Instr = I_ADD; Req0Tag = 4'd5;
    Req1Valid = 1'b1; Req1Op1 = 32'd40; Req1Op2 = 32'd2; Req1Instr = I_ADD; Req1Tag = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (last_g0 !== 1'b0 || last_g1 !== 1'b1 || Rsp0Valid !== 1'b1 || Rsp0Data !== 32'hFF) begin
        n_fail++;
        $display("FAIL blocked[%0d]: g0=%b g1=%b v0=%b d0=%h, required g0=0 g1=1 v0=1 d0=000000ff",
                 i, last_g0, last_g1, Rsp0Valid, Rsp0Data);
      end
      Req1Op1 = Req1Op1 + 32'd3; Req1Tag = Req1Tag + 4'd1;
    end
    Req1Valid = 1'b0;
    Rsp0Ready = 1'b1;
    tick();
    n_tests++;
    if (last_g0 !== 1'b1) begin
      n_fail++;
      $display("FAIL unblock: g0=%b, required 1", last_g0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    Req0Valid = 1'b1; Req0Op1 = 32'd1; Req0Op2 = 32'd1; Req0Instr = I_ADD; Req0Tag = 4'd2;
    tick();
    Req0Op1 = 32'd10; Req0Op2 = 32'd3; Req0Instr = I_SUB; Req0Tag = 4'd4;
    n_tests++;
    if (Rsp0Valid !== 1'b1 || Rsp0Data !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_first: v0=%b d0=%h, required v0=1 d0=00000002", Rsp0Valid, Rsp0Data);
    end
    tick();
    n_tests++;
    if (last_g0 !== 1'b1 || Rsp0Valid !== 1'b1 || Rsp0Data !== 32'd7 || Rsp0Tag !== 4'd4) begin
      n_fail++;
      $display("FAIL b2b_second: g0=%b v0=%b d0=%h t0=%h, required g0=1 v0=1 d0=00000007 t0=4",
               last_g0, Rsp0Valid, Rsp0Data, Rsp0Tag);
    end
    drain();
  endtask

  task automatic test_idle();
    idle_inputs();
    tick();
    n_tests++;
    if ({last_g0, last_g1, last_op1, last_op2, last_instr} !== '0) begin
      n_fail++;
      $display("FAIL idle: g=%b%b op1=%h op2=%h instr=%h, required all 0",
               last_g0, last_g1, last_op1, last_op2, last_instr);
    end
  endtask

  task automatic test_async_reset();
    Rsp1Ready = 1'b0;
    Req1Valid = 1'b1; Req1Op1 = 32'd8; Req1Op2 = 32'd9; Req1Instr = I_ADD; Req1Tag = 4'hA;
    tick();
    Req1Valid = 1'b0;
    n_tests++;
    if (Rsp1Valid !== 1'b1 || Rsp1Data !== 32'd17) begin
      n_fail++;
      $display("FAIL pre_reset: v1=%b d1=%h, required v1=1 d1=00000011", Rsp1Valid, Rsp1Data);
    end
    #2;
    RstN = 1'b0;
    #1;
    n_tests++;
    if (Rsp1Valid !== 1'b0 || Rsp1Data !== 32'd0 || Rsp1Tag !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: v1=%b d1=%h t1=%h, required all 0", Rsp1Valid, Rsp1Data, Rsp1Tag);
    end
    q1.delete();
    Rsp1Ready = 1'b1;
    @(negedge Clk);
    RstN = 1'b1;
    @(posedge Clk);
    #1;
    Req0Valid = 1'b1; Req0Op1 = 32'd3; Req0Op2 = 32'd4; Req0Instr = I_ADD; Req0Tag = 4'd1;
    Req1Valid = 1'b1; Req1Op1 = 32'd6; Req1Op2 = 32'd1; Req1Instr = I_SUB; Req1Tag = 4'd2;
    tick();
    n_tests++;
    if (last_g0 !== 1'b1 || last_g1 !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_conflict: g0=%b g1=%b, required g0=1 g1=0", last_g0, last_g1);
    end
    Req0Valid = 1'b0;
    tick();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RstN = 1'b0;
    idle_inputs();
    Rsp0Ready = 1'b1;
    Rsp1Ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_blocked();
    test_back_to_back();
    test_idle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational RV32I ALU between two requesters: port 0 (execute stage) and port 1 (address-generation / branch-compare helper).
- Each cycle, arbitrates the valid requests and drives the winner's operands and instruction word into the ALU.
- Captures AluOut into a per-requester one-entry response buffer with tag.
- Sits between the issue logic and the ALU; the ALU itself is unchanged.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU.
- INSTR_WIDTH, 32, instruction word width forwarded to the ALU.
- TAG_WIDTH, 4, opaque requester tag returned with the result.

Ports:
- Clk  in  1  clock; all state on the rising edge.
- RstN  in  1  asynchronous active-low reset.
- Req0Valid  in  1  port 0 request valid.
- Req0Ready  out  1  port 0 request accepted this cycle (grant).
- Req0Op1  in  DATA_WIDTH  port 0 operand 1.
- Req0Op2  in  DATA_WIDTH  port 0 operand 2 (register or immediate, already selected).
- Req0Instr  in  INSTR_WIDTH  port 0 instruction word.
- Req0Tag  in  TAG_WIDTH  port 0 tag.
- Req1Valid, Req1Ready, Req1Op1, Req1Op2, Req1Instr, Req1Tag: same as port 0, for port 1.
- Rsp0Valid  out  1  port 0 result valid.
- Rsp0Ready  in  1  port 0 consumer ready.
- Rsp0Data  out  DATA_WIDTH  port 0 ALU result.
- Rsp0Tag  out  TAG_WIDTH  port 0 returned tag.
- Rsp1Valid, Rsp1Ready, Rsp1Data, Rsp1Tag: same as port 0, for port 1.
- AluOp1  out  DATA_WIDTH  to ALU operand 1.
- AluOp2  out  DATA_WIDTH  to ALU operand 2.
- AluInstr  out  INSTR_WIDTH  to ALU instruction input.
- AluOut  in  DATA_WIDTH  from ALU result.

Behaviour:
- Reset (RstN low, asynchronous) forces:
  - RspNValid=0, RspNData=0, RspNTag=0.
  - LastGrant=1, so port 0 wins the first conflict.
  - A request transfer or buffered result in flight at reset is discarded; no response is produced for it.
- Eligibility: port N is eligible when ReqNValid=1 and its response slot can accept, i.e. !RspNValid || RspNReady.
- Arbitration (combinational, same cycle):
  - One eligible port: it is granted.
  - Both eligible: round-robin, the port not equal to LastGrant wins.
  - LastGrant updates to the granted port only on a grant.
- ReqNReady=1 only for the granted port; never both. A handshake is ReqNValid && ReqNReady.
- ALU drive:
  - While a grant exists, AluOp1/AluOp2/AluInstr equal the granted port's inputs.
  - With no grant, all three are 0. Instr=0 decodes to ADD, which is harmless.
- Latency: 1 cycle. On the handshake edge the granted slot loads RspNData=AluOut and RspNTag=ReqNTag, and sets RspNValid=1.
- Response hold: while RspNValid && !RspNReady, Data and Tag stay stable.
- RspNValid clears on RspNValid && RspNReady unless a new grant to N happens in the same cycle. In that case the slot reloads and Valid stays 1 (back-to-back throughput of 1 per cycle per port).
- A full, non-draining slot blocks only its own port; the other port may be granted every cycle.
- Requester rule: Req inputs must be held stable while ReqNValid && !ReqNReady; the arbiter relies on this.
- The arbiter does not decode the instruction; opcode/funct checks stay in the ALU.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 0 always wins when both ports are eligible, and LastGrant is unused. Port 1 can starve; this is accepted for execute-stage priority.
- Not defined: round-robin exactly as described in Behaviour.
- Ports and latency are identical in both builds.

Test Plan:
- Reset release, Req0 ADD with Op1=5, Op2=7, Tag=3, Rsp0Ready=1.
  -> Req0Ready=1 in cycle 0; next cycle Rsp0Valid=1, Rsp0Data=12, Rsp0Tag=3; Rsp1Valid stays 0.
- Both ports valid every cycle, both RspReady=1, round-robin build.
  -> Grants alternate 0,1,0,1 starting with port 0.
  -> Fixed-priority build: port 0 granted on all 4 cycles, Req1Ready=0 throughout.
- Rsp0Ready=0 with a result held (Data=0x0000_00FF), Req0Valid=1, Req1Valid=1.
  -> Req0Ready=0; port 1 granted each cycle; Rsp0Data stays 0xFF until Rsp0Ready=1.
- Rsp0Valid=1 and Rsp0Ready=1 in the same cycle as a new Req0 SUB, Op1=10, Op2=3 (Funct7 alt).
  -> Rsp0Valid stays 1 and next-cycle Rsp0Data=7 (no bubble).
- No requests.
  -> AluOp1=AluOp2=AluInstr=0 and both ReqReady=0.
- RstN asserted low mid-cycle while Rsp1Valid=1.
  -> Rsp1Valid drops to 0 immediately (asynchronous); after release, the first conflict is granted to port 0.
